// File: rtl/lsu_ctrl_pkg.sv
// Shared definitions for the load/store unit controller: FSM states, access
// size codes, byte-enable generation and the alignment legality check.
package lsu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_RESP = 2'b10,
    ST_ERR  = 2'b11
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'b00,
    SZ_HALF  = 2'b01,
    SZ_WORD  = 2'b10,
    SZ_DWORD = 2'b11
  } lsu_size_e;

  // Width of the bus timeout counter; covers TMO up to 65535.
  localparam int unsigned TMO_CNT_W = 16;

  // Byte enables for an access of the given size starting at byte lane off.
  // Returned for an 8-lane bus; narrower buses keep the low lanes.
  function automatic logic [7:0] be_calc(input lsu_size_e size, input logic [2:0] off);
    logic [7:0] base;
    case (size)
      SZ_BYTE: base = 8'h01;
      SZ_HALF: base = 8'h03;
      SZ_WORD: base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << off;
  endfunction

  // An access is illegal when the address is not a multiple of its size, or
  // when a dword is requested on a 32-bit bus.
  function automatic logic access_illegal(input lsu_size_e size, input logic [2:0] addr_lo,
                                          input logic dw64);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = |addr_lo[1:0];
      default: bad = (|addr_lo) | ~dw64;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Load data alignment: shifts the addressed bytes of the bus word down to
// bit 0, keeps the access size and sign- or zero-extends to the full width.
module lsu_align
  import lsu_ctrl_pkg::*;
#(
  parameter  int DW   = 32,
  localparam int OFFW = $clog2(DW / 8)
) (
  input  logic [DW-1:0]   rdata_i,
  input  logic [OFFW-1:0] off_i,
  input  lsu_size_e       size_i,
  input  logic            uload_i,
  output logic [DW-1:0]   data_o
);

  logic [DW-1:0] shifted_s;
  logic [DW-1:0] mask_s;
  logic          sign_s;

  // Shift, keep the sized field, then fill the upper bits with zero or sign.
  always_comb begin
    shifted_s = rdata_i >> {off_i, 3'b000};
    case (size_i)
      SZ_BYTE: begin
        mask_s = DW'(8'hFF);
        sign_s = shifted_s[7];
      end
      SZ_HALF: begin
        mask_s = DW'(16'hFFFF);
        sign_s = shifted_s[15];
      end
      SZ_WORD: begin
        mask_s = DW'(32'hFFFF_FFFF);
        sign_s = shifted_s[31];
      end
      default: begin
        mask_s = {DW{1'b1}};
        sign_s = shifted_s[DW-1];
      end
    endcase
    if (uload_i || !sign_s) begin
      data_o = shifted_s & mask_s;
    end else begin
      data_o = (shifted_s & mask_s) | ~mask_s;
    end
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: accepts one core access at a time, checks its
// alignment, drives a request/grant bus, waits for read data on loads and
// reports completion, misalignment or bus timeout with one-cycle pulses.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int DW  = 32,
  parameter int AW  = 32,
  parameter int TMO = 255
) (
  input  logic            i_CLK,
  input  logic            i_RSTn,
  input  logic [DW-1:0]   i_WDATA,
  input  logic [AW-1:0]   i_ADDR,
  input  logic            i_WE,
  input  logic            i_RE,
  input  logic [1:0]      i_HB,
  input  logic            i_ULOAD,
  output logic [DW-1:0]   o_RDATA,
  output logic            o_BUSY,
  output logic            o_DONE,
  output logic            o_MISALIGN,
  output logic            o_BUSERR,
  output logic [AW-1:0]   o_LSU_ADDR,
  output logic [DW-1:0]   o_LSU_WDATA,
  output logic [DW/8-1:0] o_LSU_BE,
  output logic            o_LSU_WE,
  output logic            o_LSU_REQ,
  input  logic            i_LSU_GNT,
  input  logic            i_LSU_RVALID,
  input  logic [DW-1:0]   i_LSU_RDATA
);

  localparam int BW   = DW / 8;
  localparam int OFFW = $clog2(BW);
  localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TMO - 1);

  lsu_state_e           state_q, state_d;
  logic [TMO_CNT_W-1:0] cnt_q, cnt_d;

  logic          core_req_s, pulse_s, accept_s, illegal_s, timeout_s, busy_s;
  lsu_size_e     req_size_s;
  logic [2:0]    req_off_s;
  logic [7:0]    be_full_s;
  logic [DW-1:0] lane_wdata_s;
  logic [DW-1:0] fmt_s;

  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [BW-1:0]   be_q, be_d;
  logic            we_q, we_d;
  logic            req_q, req_d;
  lsu_size_e       size_q, size_d;
  logic            uload_q, uload_d;
  logic [OFFW-1:0] off_q, off_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            done_q, done_d;
  logic            misalign_q, misalign_d;
  logic            buserr_q, buserr_d;

  // A request is not taken in the cycle a completion pulse is shown: the core
  // still holds the finished access there and it must not be replayed.
  assign core_req_s = i_WE | i_RE;
  assign pulse_s    = done_q | misalign_q | buserr_q;
  assign accept_s   = (state_q == ST_IDLE) & core_req_s & ~pulse_s;
  assign req_size_s = lsu_size_e'(i_HB);
  assign req_off_s  = 3'(i_ADDR[OFFW-1:0]);
  assign illegal_s  = access_illegal(req_size_s, i_ADDR[2:0], DW == 64);
  assign be_full_s  = be_calc(req_size_s, req_off_s);
  assign timeout_s  = (cnt_q == TMO_LAST);

  // Replicate the store data across every lane so the addressed lane holds it.
  always_comb begin
    lane_wdata_s = '0;
    for (int i = 0; i < BW; i++) begin
      case (req_size_s)
        SZ_BYTE: lane_wdata_s[i*8 +: 8] = i_WDATA[7:0];
        SZ_HALF: lane_wdata_s[i*8 +: 8] = i_WDATA[(i % 2)*8 +: 8];
        SZ_WORD: lane_wdata_s[i*8 +: 8] = i_WDATA[(i % 4)*8 +: 8];
        default: lane_wdata_s[i*8 +: 8] = i_WDATA[i*8 +: 8];
      endcase
    end
  end

  lsu_align #(.DW(DW)) u_align (
    .rdata_i (i_LSU_RDATA),
    .off_i   (off_q),
    .size_i  (size_q),
    .uload_i (uload_q),
    .data_o  (fmt_s)
  );

  // FSM state and timeout counter registers.
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and timeout counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          if (illegal_s) begin
            state_d = ST_ERR;
          end else begin
            state_d = ST_REQ;
            cnt_d   = '0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (i_LSU_GNT) begin
          state_d = we_q ? ST_IDLE : ST_RESP;
          cnt_d   = '0;
        end else if (timeout_s) begin
          state_d = ST_ERR;
          cnt_d   = cnt_q + 1'b1;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        if (i_LSU_RVALID) begin
          state_d = ST_IDLE;
        end else if (timeout_s) begin
          state_d = ST_ERR;
          cnt_d   = cnt_q + 1'b1;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values: capture on acceptance, pulses, bus request.
  always_comb begin
    done_d     = 1'b0;
    misalign_d = 1'b0;
    buserr_d   = 1'b0;
    req_d      = req_q;
    rdata_d    = rdata_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    we_d       = we_q;
    size_d     = size_q;
    uload_d    = uload_q;
    off_d      = off_q;
    busy_s     = ~pulse_s & ((state_q != ST_IDLE) | core_req_s);
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          if (illegal_s) begin
            misalign_d = 1'b1;
            req_d      = 1'b0;
          end else begin
            req_d   = 1'b1;
            addr_d  = {i_ADDR[AW-1:OFFW], {OFFW{1'b0}}};
            wdata_d = lane_wdata_s;
            be_d    = be_full_s[BW-1:0];
            we_d    = i_WE;
            size_d  = req_size_s;
            uload_d = i_ULOAD;
            off_d   = i_ADDR[OFFW-1:0];
          end
        end else begin
          req_d = 1'b0;
        end
      end
      ST_REQ: begin
        if (i_LSU_GNT) begin
          req_d  = 1'b0;
          done_d = we_q;
        end else if (timeout_s) begin
          req_d    = 1'b0;
          buserr_d = 1'b1;
        end else begin
          req_d = 1'b1;
        end
      end
      ST_RESP: begin
        req_d = 1'b0;
        if (i_LSU_RVALID) begin
          rdata_d = fmt_s;
          done_d  = 1'b1;
        end else if (timeout_s) begin
          buserr_d = 1'b1;
        end else begin
          buserr_d = 1'b0;
        end
      end
      ST_ERR:  req_d = 1'b0;
      default: req_d = 1'b0;
    endcase
  end

  // Registered outputs and captured access attributes.
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
      buserr_q   <= 1'b0;
      req_q      <= 1'b0;
      rdata_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      we_q       <= 1'b0;
      size_q     <= SZ_BYTE;
      uload_q    <= 1'b0;
      off_q      <= '0;
    end else begin
      done_q     <= done_d;
      misalign_q <= misalign_d;
      buserr_q   <= buserr_d;
      req_q      <= req_d;
      rdata_q    <= rdata_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      we_q       <= we_d;
      size_q     <= size_d;
      uload_q    <= uload_d;
      off_q      <= off_d;
    end
  end

  assign o_RDATA     = rdata_q;
  assign o_BUSY      = busy_s;
  assign o_DONE      = done_q;
  assign o_MISALIGN  = misalign_q;
  assign o_BUSERR    = buserr_q;
  assign o_LSU_ADDR  = addr_q;
  assign o_LSU_WDATA = wdata_q;
  assign o_LSU_BE    = be_q;
  assign o_LSU_WE    = we_q;
  assign o_LSU_REQ   = req_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: a 32-bit instance (TMO=8) and a 64-bit
// instance share stimulus; completions are checked against a scoreboard.
module tb_lsu_ctrl;

  localparam logic [2:0] K_DONE = 3'b001;
  localparam logic [2:0] K_BERR = 3'b010;
  localparam logic [2:0] K_MIS  = 3'b100;

  typedef struct packed {
    logic [2:0]  kind;
    logic [7:0]  lat;
    logic        chk_rd;
    logic [63:0] rd;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, sel64;
  logic [63:0] wdata, bus_rd;
  logic [31:0] addr;
  logic [1:0]  hb;
  logic        uload, gnt, rvalid, we32, re32, we64, re64;

  logic [31:0] rd32, la32, lw32;
  logic [3:0]  be32;
  logic        busy32, done32, mis32, berr32, lwe32, lreq32;
  logic [63:0] rd64, lw64;
  logic [31:0] la64;
  logic [7:0]  be64;
  logic        busy64, done64, mis64, berr64, lwe64, lreq64;

  lsu_ctrl #(.DW(32), .AW(32), .TMO(8)) u_dut32 (
    .i_CLK(clk), .i_RSTn(rst_n), .i_WDATA(wdata[31:0]), .i_ADDR(addr),
    .i_WE(we32), .i_RE(re32), .i_HB(hb), .i_ULOAD(uload),
    .o_RDATA(rd32), .o_BUSY(busy32), .o_DONE(done32), .o_MISALIGN(mis32),
    .o_BUSERR(berr32), .o_LSU_ADDR(la32), .o_LSU_WDATA(lw32), .o_LSU_BE(be32),
    .o_LSU_WE(lwe32), .o_LSU_REQ(lreq32), .i_LSU_GNT(gnt),
    .i_LSU_RVALID(rvalid), .i_LSU_RDATA(bus_rd[31:0])
  );

  lsu_ctrl #(.DW(64), .AW(32), .TMO(8)) u_dut64 (
    .i_CLK(clk), .i_RSTn(rst_n), .i_WDATA(wdata), .i_ADDR(addr),
    .i_WE(we64), .i_RE(re64), .i_HB(hb), .i_ULOAD(uload),
    .o_RDATA(rd64), .o_BUSY(busy64), .o_DONE(done64), .o_MISALIGN(mis64),
    .o_BUSERR(berr64), .o_LSU_ADDR(la64), .o_LSU_WDATA(lw64), .o_LSU_BE(be64),
    .o_LSU_WE(lwe64), .o_LSU_REQ(lreq64), .i_LSU_GNT(gnt),
    .i_LSU_RVALID(rvalid), .i_LSU_RDATA(bus_rd)
  );

  logic [63:0] ob_rd, ob_wd;
  logic [31:0] ob_addr;
  logic [7:0]  ob_be;
  logic        ob_busy, ob_done, ob_mis, ob_berr, ob_req, ob_we;

  // Observe whichever instance the current step targets.
  always_comb begin
    if (sel64) begin
      ob_rd = rd64; ob_wd = lw64; ob_addr = la64; ob_be = be64;
      ob_busy = busy64; ob_done = done64; ob_mis = mis64; ob_berr = berr64;
      ob_req = lreq64; ob_we = lwe64;
    end else begin
      ob_rd = {32'h0, rd32}; ob_wd = {32'h0, lw32}; ob_addr = la32; ob_be = {4'h0, be32};
      ob_busy = busy32; ob_done = done32; ob_mis = mis32; ob_berr = berr32;
      ob_req = lreq32; ob_we = lwe32;
    end
  end

  logic        snap_busy0, snap_req0, snap_req1, snap_we1, req_seen;
  logic [31:0] snap_addr1;
  logic [7:0]  snap_be1;
  logic [63:0] snap_wd1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_res(input logic [2:0] kind, input int lat, input logic chk_rd,
                            input logic [63:0] rd);
    exp_t e;
    e.kind = kind; e.lat = 8'(lat); e.chk_rd = chk_rd; e.rd = rd;
    sb.push_back(e);
  endtask

  // One core access: request held from cycle 0 until a completion pulse,
  // grant and read-valid offered in the given cycles (-1 = never).
  task automatic txn(input string tag, input logic is64, input logic we, input logic re,
                     input logic [1:0] size, input logic uld, input logic [31:0] a,
                     input logic [63:0] wd, input int gnt_at, input int rv_at,
                     input logic [63:0] brd);
    logic seen;
    exp_t e;
    seen = 1'b0;
    req_seen = 1'b0;
    sel64 = is64;
    for (int c = 0; (c < 40) && !seen; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        addr = a; wdata = wd; hb = size; uload = uld;
        if (is64) begin we64 = we; re64 = re; end
        else begin we32 = we; re32 = re; end
      end
      gnt = (c == gnt_at);
      rvalid = (c == rv_at);
      bus_rd = (c == rv_at) ? brd : 64'hA5A5_5A5A_DEAD_BEEF;
      #3;
      if (c == 0) begin snap_busy0 = ob_busy; snap_req0 = ob_req; end
      if (c == 1) begin
        snap_req1 = ob_req; snap_we1 = ob_we; snap_addr1 = ob_addr;
        snap_be1 = ob_be; snap_wd1 = ob_wd;
      end
      if (ob_req) req_seen = 1'b1;
      if (ob_done | ob_mis | ob_berr) begin
        seen = 1'b1;
        if (sb.size() == 0) begin
          chk({tag, "/unexpected_pulse"}, 64'({ob_mis, ob_berr, ob_done}), 64'd0);
        end else begin
          e = sb.pop_front();
          chk({tag, "/kind"}, 64'({ob_mis, ob_berr, ob_done}), 64'(e.kind));
          chk({tag, "/cycle"}, 64'(c), 64'(e.lat));
          chk({tag, "/busy_at_pulse"}, 64'(ob_busy), 64'd0);
          chk({tag, "/lsu_req_at_pulse"}, 64'(ob_req), 64'd0);
          if (e.chk_rd) chk({tag, "/rdata"}, ob_rd, e.rd);
        end
      end
    end
    chk({tag, "/completed"}, 64'(seen), 64'd1);
    @(posedge clk); #1;
    we32 = 1'b0; re32 = 1'b0; we64 = 1'b0; re64 = 1'b0; gnt = 1'b0; rvalid = 1'b0;
    #3;
    chk({tag, "/post_pulses"}, 64'({ob_mis, ob_berr, ob_done}), 64'd0);
    chk({tag, "/post_busy"}, 64'(ob_busy), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; sel64 = 1'b0;
    we32 = 1'b0; re32 = 1'b0; we64 = 1'b0; re64 = 1'b0;
    wdata = '0; addr = '0; hb = 2'b00; uload = 1'b0;
    gnt = 1'b0; rvalid = 1'b0; bus_rd = '0;
    repeat (2) @(posedge clk);
    #4;
    chk("rst/rdata32", 64'(rd32), 64'd0);
    chk("rst/pulses32", 64'({done32, mis32, berr32}), 64'd0);
    chk("rst/bus32", 64'({lreq32, lwe32, be32}), 64'd0);
    chk("rst/rdata64", rd64, 64'd0);
    chk("rst/bus64", 64'({lreq64, lwe64, be64}), 64'd0);
    chk("rst/busy32", 64'(busy32), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Signed byte load at 0x103.
    expect_res(K_DONE, 3, 1'b1, 64'h0000_0000_FFFF_FF80);
    txn("lb", 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 32'h103, 64'd0, 1, 2, 64'h80FF_FFFF);
    chk("lb/busy_c0", 64'(snap_busy0), 64'd1);
    chk("lb/req_c0", 64'(snap_req0), 64'd0);
    chk("lb/req_c1", 64'(snap_req1), 64'd1);
    chk("lb/addr", 64'(snap_addr1), 64'h100);
    chk("lb/be", 64'(snap_be1), 64'h08);
    chk("lb/we", 64'(snap_we1), 64'd0);

    // Unsigned byte load from the same word.
    expect_res(K_DONE, 3, 1'b1, 64'h0000_0000_0000_0080);
    txn("lbu", 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 32'h103, 64'd0, 1, 2, 64'h80FF_FFFF);

    // Signed half load, grant late in cycle 3, data in cycle 5.
    expect_res(K_DONE, 6, 1'b1, 64'h0000_0000_FFFF_80FF);
    txn("lh", 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 32'h102, 64'd0, 3, 5, 64'h80FF_1234);

    // Half store at 0x102; load result must be left untouched.
    expect_res(K_DONE, 2, 1'b1, 64'h0000_0000_FFFF_80FF);
    txn("sh", 1'b0, 1'b1, 1'b0, 2'b01, 1'b1, 32'h102, 64'h0000_BEEF, 1, -1, 64'd0);
    chk("sh/wdata_hi", 64'(snap_wd1[31:16]), 64'hBEEF);
    chk("sh/be", 64'(snap_be1), 64'h0C);
    chk("sh/addr", 64'(snap_addr1), 64'h100);
    chk("sh/we", 64'(snap_we1), 64'd1);

    // Misaligned word load: no bus request even with a grant offered.
    expect_res(K_MIS, 1, 1'b0, 64'd0);
    txn("lw_mis", 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h101, 64'd0, 1, 2, 64'd0);
    chk("lw_mis/no_req", 64'(req_seen), 64'd0);

    // Grant withheld: timeout after 8 request cycles.
    expect_res(K_BERR, 9, 1'b0, 64'd0);
    txn("sw_tmo", 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h200, 64'h1234_5678, -1, -1, 64'd0);
    chk("sw_tmo/req_c1", 64'(snap_req1), 64'd1);

    // Read data withheld: timeout in the response phase, rdata kept.
    expect_res(K_BERR, 10, 1'b1, 64'h0000_0000_FFFF_80FF);
    txn("lw_tmo", 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h204, 64'd0, 1, -1, 64'd0);

    // Store and load together with dword size on a 32-bit bus.
    expect_res(K_MIS, 1, 1'b0, 64'd0);
    txn("sd32", 1'b0, 1'b1, 1'b1, 2'b11, 1'b0, 32'h108, 64'h1111_2222, 1, -1, 64'd0);
    chk("sd32/no_req", 64'(req_seen), 64'd0);

    // Aligned word load passes the bus word through.
    expect_res(K_DONE, 3, 1'b1, 64'h0000_0000_1357_9BDF);
    txn("lw", 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h204, 64'd0, 1, 2, 64'h1357_9BDF);

    // Reset asserted while waiting for read data.
    sel64 = 1'b0;
    @(posedge clk); #1;
    addr = 32'h104; hb = 2'b10; uload = 1'b0; re32 = 1'b1; gnt = 1'b0; rvalid = 1'b0;
    @(posedge clk); #1;
    gnt = 1'b1;
    @(posedge clk); #1;
    gnt = 1'b0;
    #1;
    chk("rst_resp/busy_in_resp", 64'(ob_busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_resp/rdata", ob_rd, 64'd0);
    chk("rst_resp/pulses", 64'({ob_mis, ob_berr, ob_done}), 64'd0);
    chk("rst_resp/bus", 64'({ob_req, ob_we, ob_be}), 64'd0);
    re32 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    rvalid = 1'b1; bus_rd = 64'h0000_0000_CAFE_F00D;
    #3;
    chk("rst_resp/late_rvalid_pulses", 64'({ob_mis, ob_berr, ob_done}), 64'd0);
    chk("rst_resp/busy_after", 64'(ob_busy), 64'd0);
    @(posedge clk); #1;
    rvalid = 1'b0;
    #3;
    chk("rst_resp/rdata_after", ob_rd, 64'd0);

    // New store after reset completes normally.
    expect_res(K_DONE, 2, 1'b1, 64'd0);
    txn("sw_post_rst", 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h300, 64'hDEAD_0001, 1, -1, 64'd0);
    chk("sw_post_rst/be", 64'(snap_be1), 64'h0F);
    chk("sw_post_rst/wdata", snap_wd1, 64'hDEAD_0001);

    // 64-bit bus: dword load at 0x8 passes data unchanged.
    expect_res(K_DONE, 3, 1'b1, 64'h0123_4567_89AB_CDEF);
    txn("ld64", 1'b1, 1'b0, 1'b1, 2'b11, 1'b0, 32'h8, 64'd0, 1, 2, 64'h0123_4567_89AB_CDEF);
    chk("ld64/be", 64'(snap_be1), 64'hFF);
    chk("ld64/addr", 64'(snap_addr1), 64'h8);

    // 64-bit bus: signed word load from the upper half.
    expect_res(K_DONE, 3, 1'b1, 64'hFFFF_FFFF_8000_0001);
    txn("lw64", 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'hC, 64'd0, 1, 2, 64'h8000_0001_0000_0000);
    chk("lw64/be", 64'(snap_be1), 64'hF0);
    chk("lw64/addr", 64'(snap_addr1), 64'h8);

    // 64-bit bus: dword at 0x4 is misaligned.
    expect_res(K_MIS, 1, 1'b0, 64'd0);
    txn("ld64_mis", 1'b1, 1'b0, 1'b1, 2'b11, 1'b0, 32'h4, 64'd0, 1, 2, 64'd0);
    chk("ld64_mis/no_req", 64'(req_seen), 64'd0);

    chk("scoreboard/empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameters SHALL be: DW, default 32, data width (32 or 64). AW, default 32, address width. TMO, default 255, bus timeout in cycles (1..65535).
REQ-002 Ports SHALL be the following.
  i_CLK  in  1  single clock, rising edge.
  i_RSTn  in  1  asynchronous active-low reset.
  i_WDATA  in  DW  store data, LSB-aligned.
  i_ADDR  in  AW  byte address.
  i_WE  in  1  store request.
  i_RE  in  1  load request.
  i_HB  in  2  size: 00 byte, 01 half, 10 word, 11 dword.
  i_ULOAD  in  1  zero-extend load when 1, sign-extend when 0.
  o_RDATA  out  DW  formatted load result.
  o_BUSY  out  1  core stall.
  o_DONE  out  1  one-cycle completion pulse.
  o_MISALIGN  out  1  one-cycle pulse: misaligned or illegal access.
  o_BUSERR  out  1  one-cycle pulse: bus timeout.
  o_LSU_ADDR  out  AW  bus address, aligned to DW/8.
  o_LSU_WDATA  out  DW  store data shifted to its byte lane.
  o_LSU_BE  out  DW/8  byte-lane enables.
  o_LSU_WE  out  1  bus write.
  o_LSU_REQ  out  1  bus request.
  i_LSU_GNT  in  1  bus grant.
  i_LSU_RVALID  in  1  read data valid.
  i_LSU_RDATA  in  DW  bus read data, full aligned word.

Function
REQ-003 The block SHALL implement a four-state FSM: IDLE, REQ, RESP, ERR.
REQ-004 IDLE: when (i_WE|i_RE) is 1 and the access is legal, the block SHALL capture address, data, size, i_ULOAD and i_WE, and go to REQ. If i_WE and i_RE are both 1, the access SHALL be treated as a store.
REQ-005 An access SHALL be illegal when any of the following holds: the address is not a multiple of its size (half: bit0 set; word: bits[1:0] nonzero; dword: bits[2:0] nonzero), or i_HB=11 with DW=32.
REQ-006 An illegal access SHALL go to ERR, pulse o_MISALIGN one cycle later, and issue no bus request.
REQ-007 In REQ, o_LSU_REQ SHALL be 1, and address, data, BE and WE SHALL stay stable until the cycle where i_LSU_GNT=1.
REQ-008 On grant: a store SHALL pulse o_DONE in the next cycle and return to IDLE; a load SHALL go to RESP.
REQ-009 In RESP, o_LSU_REQ SHALL be 0. On i_LSU_RVALID=1 the block SHALL register the formatted data into o_RDATA, pulse o_DONE in the next cycle, and return to IDLE.
REQ-010 Load formatting SHALL right-shift i_LSU_RDATA by (addr offset × 8), keep 8/16/32/64 bits per size, then sign-extend or zero-extend to DW per i_ULOAD. A DW-wide access SHALL pass through unchanged.
REQ-011 Stores SHALL replicate the data to lane (addr offset). o_LSU_BE SHALL have 1/2/4/8 contiguous bits set starting at the offset. Loads SHALL drive BE the same way.
REQ-012 A TMO-cycle counter SHALL clear on entry to REQ and to RESP, and increment each cycle spent there. Reaching TMO SHALL cause ERR, a one-cycle o_BUSERR pulse, and release of o_LSU_REQ.
REQ-013 ERR SHALL last one cycle and then return to IDLE; it SHALL NOT assert o_DONE.
REQ-014 o_BUSY SHALL be 1 in REQ, RESP and ERR, and in IDLE while a request is presented. It SHALL be 0 in the cycle o_DONE, o_MISALIGN or o_BUSERR is 1.
REQ-015 o_RDATA SHALL hold its last value until the next load completes; a store SHALL NOT modify it.
REQ-016 Minimum latency SHALL be: store, request in cycle 0 with grant in cycle 1 gives o_DONE in cycle 2; load, additionally RVALID in cycle 2 gives o_DONE and o_RDATA in cycle 3.
REQ-017 Core requests presented while state≠IDLE SHALL be ignored; the core holds the request until it sees o_DONE.

Reset
REQ-018 While i_RSTn=0: state SHALL be IDLE, and o_RDATA, o_DONE, o_MISALIGN, o_BUSERR, o_LSU_REQ, o_LSU_WE, o_LSU_BE and the counter SHALL be 0. Any in-flight access SHALL be abandoned and not replayed.
REQ-019 Deassertion of i_RSTn SHALL take effect at the first rising edge of i_CLK and need no further cycles.

Structure
REQ-020 The state encoding, the size codes (00/01/10/11), and a function computing BE from size and offset SHALL live in the shared core header/package.
REQ-021 Load alignment and extension SHALL be a combinational sub-module lsu_align, instantiated once.

Verification
REQ-022 The bench SHALL cover these directed scenarios (DW=32, TMO=8).
  Signed byte load, addr 0x103, RDATA 0x80FF_FFFF, GNT in cycle 1, RVALID in cycle 2 -> o_RDATA=0xFFFF_FF80, o_DONE in cycle 3.
  Unsigned half store, addr 0x102, WDATA 0x0000_BEEF -> o_LSU_WDATA=0xBEEF_xxxx, BE=1100, ADDR=0x100, o_DONE in cycle 2.
  Word load at 0x101 -> o_MISALIGN pulse in cycle 1, o_LSU_REQ stays 0, no o_DONE.
  Grant withheld -> o_BUSERR pulse after 8 REQ cycles, then o_LSU_REQ=0 and IDLE.
  i_RSTn low while in RESP -> all outputs 0; after release, a new store completes normally.
  i_WE=i_RE=1, dword size with DW=32 -> o_MISALIGN; dword load with DW=64 at 0x8 -> BE=0xFF, data unchanged.
